instr_sequencer: RTL and testbench

//  Run-control FSM and program counter for the 9-bit accumulator core.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/seq_pc.sv | 38 +++
 rtl/instr_sequencer.sv | 144 ++++++++++++++
 tb/tb_instr_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg
//  Shared definitions for the instruction sequencer:
//  - seq_state_t : run-control FSM state encoding
//  - pc_sel_t    : program-counter update select
//  - default widths and load latency
package seq_pkg;

  localparam int DEF_PC_W    = 10;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_MEM_LAT = 1;
  localparam int WAIT_W      = 3;   // holds MEM_LAT in 0..7

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LWAIT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/seq_pc.sv
// seq_pc
//  Program-counter register for the sequencer.
//  Ports:
//   Clk     in  rising-edge clock
//   Reset   in  asynchronous active-low clear (PC -> 0)
//   Sel     in  PC_HOLD / PC_LOAD / PC_INC
//   LoadVal in  value taken on PC_LOAD (ProgBase or branch target)
//   PC      out current instruction-ROM address
module seq_pc
  import seq_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [1:0]      Sel,
  input  logic [PC_W-1:0] LoadVal,
  output logic [PC_W-1:0] PC
);

  logic [PC_W-1:0] r_pc;

  // Increment wraps naturally at all-ones.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc <= '0;
    end else begin
      case (Sel)
        PC_LOAD: r_pc <= LoadVal;
        PC_INC:  r_pc <= r_pc + 1'b1;
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign PC = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
//  Run-control FSM and program counter for the 9-bit accumulator core.
//  Ports:
//   Clk, Reset (async active-low)
//   Start      harness run request (level), ProgBase start address
//   BranchEn, MemRead, HaltReq  decoder flags for the current instruction
//   AccNonZero bne taken condition, Target branch target
//   PC         instruction-ROM address
//   WrGate     commit qualifier (high only on an instruction's commit cycle)
//   Busy       high in RUN/LWAIT, Done run-complete acknowledge
//   CycleCnt   saturating RUN+LWAIT cycle count of the current/last run
//   DbgState   current FSM state (seq_state_t encoding)
//  Handshake: Start is a level request. Once a run halts, Done stays high
//  until Start is seen low, then the FSM returns to IDLE (4-phase).
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  ProgBase,
  input  logic             BranchEn,
  input  logic             MemRead,
  input  logic             HaltReq,
  input  logic             AccNonZero,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PC,
  output logic             WrGate,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [1:0]       DbgState
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_cnt;

  pc_sel_t           w_pc_sel;
  logic [PC_W-1:0]   w_pc_load;
  logic              w_wr;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_wait_load;
  logic              w_wait_dec;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and per-cycle controls. WrGate is combinational on state and
  // decoder flags, so it falls the instant Reset goes low.
  always_comb begin
    w_next_state = r_state;
    w_pc_sel     = PC_HOLD;
    w_pc_load    = Target;
    w_wr         = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_wait_load  = 1'b0;
    w_wait_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_next_state = ST_RUN;
          w_pc_sel     = PC_LOAD;
          w_pc_load    = ProgBase;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_RUN: begin
        w_cnt_inc = 1'b1;
        // Halt beats everything; a load beats a branch (illegal combo).
        if (HaltReq) begin
          w_next_state = ST_DONE;
        end else if (MemRead && (MEM_LAT > 0)) begin
          w_wait_load  = 1'b1;
          w_next_state = ST_LWAIT;
        end else begin
          w_wr = 1'b1;
          if (BranchEn && AccNonZero) w_pc_sel = PC_LOAD;
          else                        w_pc_sel = PC_INC;
        end
      end
      ST_LWAIT: begin
        w_cnt_inc  = 1'b1;
        w_wait_dec = 1'b1;
        if (r_wait == WAIT_W'(1)) begin
          w_wr         = 1'b1;
          w_pc_sel     = PC_INC;
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!Start) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wait <= '0;
    end else if (w_wait_load) begin
      r_wait <= WAIT_INIT;
    end else if (w_wait_dec) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  // Saturating run-cycle counter; holds outside RUN/LWAIT.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  seq_pc #(.PC_W(PC_W)) u_pc (
    .Clk     (Clk),
    .Reset   (Reset),
    .Sel     (w_pc_sel),
    .LoadVal (w_pc_load),
    .PC      (PC)
  );

  assign WrGate   = w_wr;
  assign Busy     = (r_state == ST_RUN) || (r_state == ST_LWAIT);
  assign Done     = (r_state == ST_DONE);
  assign CycleCnt = r_cnt;
  assign DbgState = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int M_LAT = 2;
  localparam int VW    = 2 + PC_W + 3 + CNT_W;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Reset;
  logic             Start, BranchEn, MemRead, HaltReq, AccNonZero;
  logic [PC_W-1:0]  ProgBase, Target;

  logic [PC_W-1:0]  PC;
  logic             WrGate, Busy, Done;
  logic [CNT_W-1:0] CycleCnt;
  logic [1:0]       DbgState;

  logic [PC_W-1:0]  PC_s;
  logic             WrGate_s, Busy_s, Done_s;
  logic [3:0]       CycleCnt_s;
  logic [1:0]       DbgState_s;

  instr_sequencer #(.PC_W(PC_W), .MEM_LAT(M_LAT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgBase(ProgBase),
    .BranchEn(BranchEn), .MemRead(MemRead), .HaltReq(HaltReq),
    .AccNonZero(AccNonZero), .Target(Target), .PC(PC), .WrGate(WrGate),
    .Busy(Busy), .Done(Done), .CycleCnt(CycleCnt), .DbgState(DbgState)
  );

  // Zero-latency loads and a 4-bit counter to reach saturation quickly.
  instr_sequencer #(.PC_W(PC_W), .MEM_LAT(0), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgBase(ProgBase),
    .BranchEn(BranchEn), .MemRead(MemRead), .HaltReq(HaltReq),
    .AccNonZero(AccNonZero), .Target(Target), .PC(PC_s), .WrGate(WrGate_s),
    .Busy(Busy_s), .Done(Done_s), .CycleCnt(CycleCnt_s), .DbgState(DbgState_s)
  );

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model of the sequencer (MEM_LAT = M_LAT).
  int               m_state;
  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;
  int               m_wait;

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_cnt = '0; m_wait = 0;
  endtask

  function automatic logic [VW-1:0] model_out();
    logic wr, busy, done;
    wr = 1'b0;
    if (m_state == 1 && !HaltReq && !MemRead) wr = 1'b1;
    if (m_state == 2 && m_wait == 1)          wr = 1'b1;
    busy = (m_state == 1) || (m_state == 2);
    done = (m_state == 3);
    return {2'(m_state), m_pc, wr, busy, done, m_cnt};
  endfunction

  task automatic model_step();
    case (m_state)
      0: if (Start) begin m_state = 1; m_pc = ProgBase; m_cnt = '0; end
      1: begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
        if (HaltReq)                       m_state = 3;
        else if (MemRead)                  begin m_wait = M_LAT; m_state = 2; end
        else if (BranchEn && AccNonZero)   m_pc = Target;
        else                               m_pc = m_pc + 1'b1;
      end
      2: begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
        if (m_wait == 1) begin m_pc = m_pc + 1'b1; m_state = 1; end
        m_wait = m_wait - 1;
      end
      default: if (!Start) m_state = 0;
    endcase
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge: drive, push expectation, sample #1 later,
  // advance the model, then wait for the next negedge.
  task automatic cyc(input logic st, input logic br, input logic mr,
                     input logic hr, input logic nz, input logic [PC_W-1:0] tgt);
    logic [VW-1:0] got, e;
    Start = st; BranchEn = br; MemRead = mr; HaltReq = hr; AccNonZero = nz; Target = tgt;
    exp_q.push_back(model_out());
    #1;
    got = {DbgState, PC, WrGate, Busy, Done, CycleCnt};
    e = exp_q.pop_front();
    check("cyc", 64'(got), 64'(e));
    model_step();
    @(negedge Clk);
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b0; Start = 0; BranchEn = 0; MemRead = 0; HaltReq = 0;
    AccNonZero = 0; ProgBase = '0; Target = '0;
    model_reset();
    repeat (2) @(negedge Clk);
    check("rst_pc", 64'(PC), 64'h0);
    check("rst_flags", 64'({WrGate, Busy, Done}), 64'h0);
    check("rst_cnt", 64'(CycleCnt), 64'h0);
    Reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);

    // three ALU ops then halt from 0x010
    ProgBase = 10'h010;
    cyc(1, 0, 0, 0, 0, 0);
    check("t2_pc0", 64'(PC), 64'h010);
    cyc(1, 0, 0, 0, 0, 0);
    check("t2_pc1", 64'(PC), 64'h011);
    cyc(1, 0, 0, 0, 0, 0);
    check("t2_pc2", 64'(PC), 64'h012);
    cyc(1, 0, 0, 0, 0, 0);
    check("t2_pc3", 64'(PC), 64'h013);
    cyc(1, 0, 0, 1, 0, 0);
    check("t2_done", 64'(Done), 64'h1);
    check("t2_cnt", 64'(CycleCnt), 64'd4);
    check("t2_pc_hold", 64'(PC), 64'h013);

    // handshake: Done holds while Start stays high
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
    check("t5_done_hold", 64'(Done), 64'h1);
    cyc(0, 0, 0, 0, 0, 0);
    check("t5_idle", 64'({DbgState, Done}), 64'h0);
    ProgBase = 10'h005;
    cyc(1, 0, 0, 0, 0, 0);
    check("t5_restart_pc", 64'(PC), 64'h005);

    // load at 0x005 with MEM_LAT=2
    cyc(1, 0, 1, 0, 0, 0);
    check("t3_pc_w1", 64'(PC), 64'h005);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    check("t3_pc_after", 64'(PC), 64'h006);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // bne at 0x020
    ProgBase = 10'h020;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 10'h008);
    check("t4_taken", 64'(PC), 64'h008);
    cyc(1, 1, 0, 0, 1, 10'h020);
    cyc(1, 1, 0, 0, 0, 10'h008);
    check("t4_not_taken", 64'(PC), 64'h021);
    cyc(1, 1, 0, 0, 1, 10'h021);  // tight loop: Target == PC
    check("t4_tight", 64'(PC), 64'h021);
    cyc(1, 1, 1, 0, 1, 10'h100);  // branch+load: treated as load
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("t4_brld", 64'(PC), 64'h022);
    cyc(1, 1, 0, 1, 1, 10'h008);  // halt beats branch
    check("t4_halt_br", 64'({Done, PC}), {1'b1, 10'h022});
    cyc(0, 0, 0, 0, 0, 0);

    // reset low mid-LWAIT
    ProgBase = 10'h040;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);        // Start drop during run is ignored
    Reset = 1'b0;
    #1;
    check("t1_pc", 64'(PC), 64'h0);
    check("t1_busy_wr", 64'({Busy, WrGate}), 64'h0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_idle", 64'(DbgState), 64'h0);

    // PC wrap at all-ones, halt+load
    ProgBase = 10'h3FF;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("t6_wrap", 64'(PC), 64'h000);
    cyc(1, 0, 1, 1, 0, 0);        // halt beats load
    check("t6_halt_ld", 64'({Done, PC}), {1'b1, 10'h000});
    cyc(0, 0, 0, 0, 0, 0);

    // random programs
    for (int i = 0; i < 400; i++) begin
      int r;
      logic st;
      if (m_state == 3) begin
        cyc(($urandom_range(0, 2) == 0), 0, 0, 0, 0, 0);
      end else if (m_state == 0) begin
        ProgBase = PC_W'($urandom);
        cyc($urandom_range(0, 1) == 1, 0, 0, 0, 0, 0);
      end else begin
        r  = $urandom_range(0, 15);
        st = ($urandom_range(0, 3) != 0);
        if (r == 0)      cyc(st, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, 1, PC_W'($urandom));
        else if (r < 4)  cyc(st, $urandom_range(0, 1) == 1, 1, 0, $urandom_range(0, 1) == 1, PC_W'($urandom));
        else if (r < 8)  cyc(st, 1, 0, 0, $urandom_range(0, 1) == 1, PC_W'($urandom));
        else             cyc(st, 0, 0, 0, 0, PC_W'($urandom));
      end
    end

    // zero-latency load and counter saturation on dut_s
    reset_pulse();
    ProgBase = 10'h100;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    check("s_ld_pc", 64'(PC_s), 64'h101);
    check("s_ld_cnt", 64'(CycleCnt_s), 64'd1);
    for (int i = 0; i < 13; i++) cyc(1, 1, 0, 0, 1, 10'h101);
    check("s_cnt_pre", 64'(CycleCnt_s), 64'd14);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 1, 10'h101);
    check("s_cnt_sat", 64'(CycleCnt_s), 64'hF);
    check("s_tight_pc", 64'(PC_s), 64'h101);
    cyc(1, 0, 0, 1, 0, 0);
    check("s_done", 64'({Done_s, CycleCnt_s}), {1'b1, 4'hF});
    cyc(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
